// File: rtl/sensor_frame_capture_if.sv
// Sensor-side bus of the frame capture front-end: ADC/sync inputs,
// configuration/ROI inputs and the capture outputs toward the FIFO.
interface sensor_frame_capture_if #(
  parameter int unsigned ADC_W = 10,
  parameter int unsigned OUT_W = 8,
  parameter int unsigned ROW_W = 9,
  parameter int unsigned COL_W = 10,
  parameter int unsigned DEC_W = 5,
  parameter int unsigned INT_W = 21
);
  logic [ADC_W-1:0] iADATA;
  logic             Line_Valid;
  logic             Frame_Valid;
  logic             iCFG_DONE;
  logic [DEC_W-1:0] iDEC;
  logic [ROW_W-1:0] iROW_START;
  logic [ROW_W-1:0] iROW_NUM;
  logic [COL_W-1:0] iCOL_START;
  logic [COL_W-1:0] iCOL_NUM;
  logic [INT_W-1:0] iINT_LEN;

  logic             oRST_N;
  logic             oCFG_START;
  logic [OUT_W-1:0] oDATA;
  logic             oDVAL;
  logic             oSOF;
  logic             oEOF;
  logic [7:0]       oFRAME_CNT;
  logic             oINT_TIME;
  logic             oREADY;

  // Sensor / host side
  modport master (
    output iADATA, Line_Valid, Frame_Valid, iCFG_DONE, iDEC,
           iROW_START, iROW_NUM, iCOL_START, iCOL_NUM, iINT_LEN,
    input  oRST_N, oCFG_START, oDATA, oDVAL, oSOF, oEOF,
           oFRAME_CNT, oINT_TIME, oREADY
  );

  // Capture front-end side
  modport slave (
    input  iADATA, Line_Valid, Frame_Valid, iCFG_DONE, iDEC,
           iROW_START, iROW_NUM, iCOL_START, iCOL_NUM, iINT_LEN,
    output oRST_N, oCFG_START, oDATA, oDVAL, oSOF, oEOF,
           oFRAME_CNT, oINT_TIME, oREADY
  );
endinterface

// File: rtl/sensor_frame_capture.sv
// Sensor readout front-end: power-up/config sequencing, frame decimation,
// ROI crop, ADC truncation with a 2-cycle pipeline and exposure pulse.
module sensor_frame_capture #(
  parameter int unsigned ADC_W     = 10,
  parameter int unsigned OUT_W     = 8,
  parameter int unsigned PWRUP_CYC = 20000,
  parameter int unsigned RSTH_CYC  = 50,
  parameter int unsigned ROW_W     = 9,
  parameter int unsigned COL_W     = 10,
  parameter int unsigned DEC_W     = 5,
  parameter int unsigned INT_W     = 21
) (
  input  logic                   iCLOCK_80,
  input  logic                   iRST_N,
  sensor_frame_capture_if.slave  bus
);
  localparam int unsigned CYC_MAX = (PWRUP_CYC > RSTH_CYC) ? PWRUP_CYC : RSTH_CYC;
  localparam int unsigned CNT_W   = $clog2(CYC_MAX + 1);

  typedef enum logic [2:0] {PWR, HOLD, CFG, WCFG, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] cyc_cnt;
  logic             rst_n_q, cfg_start_q, ready_q;

  logic             fv_s1, fv_s2, lv_s1, lv_s2;
  logic [OUT_W-1:0] ad_s1, ad_s2;

  logic [ROW_W-1:0] row_cnt, rs_q, rn_q;
  logic [COL_W-1:0] col_cnt, cs_q, cn_q;
  logic [DEC_W-1:0] dec_cnt;
  logic             captured;
  logic             dval_q, sof_q, eof_q;
  logic [7:0]       frame_cnt;
  logic [INT_W-1:0] int_cnt;

  logic             run, fv_rise, fv_fall, lv_rise, lv_fall, start, cap_eff;
  logic [ROW_W-1:0] rs_eff, rn_eff, row_eff;
  logic [COL_W-1:0] cs_eff, cn_eff, col_eff;
  logic [ROW_W:0]   row_lo, row_hi;
  logic [COL_W:0]   col_lo, col_hi;
  logic             in_row, in_col;

  assign run     = (state == RUN);
  assign fv_rise = fv_s1 & ~fv_s2;
  assign fv_fall = ~fv_s1 & fv_s2;
  assign lv_rise = lv_s1 & ~lv_s2;
  assign lv_fall = ~lv_s1 & lv_s2;
  assign start   = fv_rise & run;

  // The pixel in s1 during the frame-start cycle already belongs to the new
  // frame, so it sees the live ROI/capture decision rather than the latches.
  assign cap_eff = start ? (dec_cnt == '0) : captured;
  assign rs_eff  = start ? bus.iROW_START : rs_q;
  assign rn_eff  = start ? bus.iROW_NUM   : rn_q;
  assign cs_eff  = start ? bus.iCOL_START : cs_q;
  assign cn_eff  = start ? bus.iCOL_NUM   : cn_q;
  assign row_eff = fv_rise ? '0 : row_cnt;
  assign col_eff = lv_rise ? '0 : col_cnt;

  // One extra bit keeps start+num from wrapping back into low rows/cols
  assign row_lo = {1'b0, rs_eff};
  assign row_hi = {1'b0, rs_eff} + {1'b0, rn_eff};
  assign col_lo = {1'b0, cs_eff};
  assign col_hi = {1'b0, cs_eff} + {1'b0, cn_eff};
  assign in_row = ({1'b0, row_eff} >= row_lo) && ({1'b0, row_eff} < row_hi);
  assign in_col = ({1'b0, col_eff} >= col_lo) && ({1'b0, col_eff} < col_hi);

  // Power-up / configuration sequencer
  always_ff @(posedge iCLOCK_80) begin
    if (!iRST_N) begin
      state       <= PWR;
      cyc_cnt     <= '0;
      rst_n_q     <= 1'b0;
      cfg_start_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      cfg_start_q <= 1'b0;
      case (state)
        PWR: begin
          if (cyc_cnt == CNT_W'(PWRUP_CYC - 1)) begin
            state   <= HOLD;
            cyc_cnt <= '0;
            rst_n_q <= 1'b1;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (cyc_cnt == CNT_W'(RSTH_CYC - 1)) begin
            state   <= CFG;
            cyc_cnt <= '0;
          end else begin
            cyc_cnt <= cyc_cnt + 1'b1;
          end
        end
        CFG: begin
          if (!fv_s2) begin
            cfg_start_q <= 1'b1;
            state       <= WCFG;
          end
        end
        WCFG: begin
          if (bus.iCFG_DONE) begin
            state   <= RUN;
            ready_q <= 1'b1;
          end
        end
        RUN:     state <= RUN;
        default: state <= PWR;
      endcase
    end
  end

  // Two-stage input register; only the kept MSBs of the ADC word travel on
  always_ff @(posedge iCLOCK_80) begin
    if (!iRST_N) begin
      fv_s1 <= 1'b0;
      fv_s2 <= 1'b0;
      lv_s1 <= 1'b0;
      lv_s2 <= 1'b0;
      ad_s1 <= '0;
      ad_s2 <= '0;
    end else begin
      fv_s1 <= bus.Frame_Valid;
      fv_s2 <= fv_s1;
      lv_s1 <= bus.Line_Valid;
      lv_s2 <= lv_s1;
      ad_s1 <= bus.iADATA[ADC_W-1 -: OUT_W];
      ad_s2 <= ad_s1;
    end
  end

  // Frame start/end, decimation, row/col counting and the write strobe
  always_ff @(posedge iCLOCK_80) begin
    if (!iRST_N) begin
      row_cnt   <= '0;
      col_cnt   <= '0;
      rs_q      <= '0;
      rn_q      <= '0;
      cs_q      <= '0;
      cn_q      <= '0;
      dec_cnt   <= '0;
      captured  <= 1'b0;
      dval_q    <= 1'b0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      dval_q <= cap_eff & lv_s1 & fv_s1 & in_row & in_col;
      sof_q  <= start & (dec_cnt == '0);
      eof_q  <= fv_fall & captured;

      if (fv_rise)      row_cnt <= '0;
      else if (lv_fall) row_cnt <= row_cnt + 1'b1;

      if (lv_s1) col_cnt <= col_eff + 1'b1;

      if (start) begin
        frame_cnt <= frame_cnt + 1'b1;
        captured  <= (dec_cnt == '0);
        dec_cnt   <= (dec_cnt >= bus.iDEC) ? '0 : dec_cnt + 1'b1;
        rs_q      <= bus.iROW_START;
        rn_q      <= bus.iROW_NUM;
        cs_q      <= bus.iCOL_START;
        cn_q      <= bus.iCOL_NUM;
      end else if (fv_fall) begin
        captured  <= 1'b0;
      end
    end
  end

  // Exposure counter, (re)loaded on every frame end seen in RUN
  always_ff @(posedge iCLOCK_80) begin
    if (!iRST_N)                int_cnt <= '0;
    else if (fv_fall && run)    int_cnt <= bus.iINT_LEN;
    else if (int_cnt != '0)     int_cnt <= int_cnt - 1'b1;
  end

  assign bus.oRST_N     = rst_n_q;
  assign bus.oCFG_START = cfg_start_q;
  assign bus.oREADY     = ready_q;
  assign bus.oDATA      = ad_s2;
  assign bus.oDVAL      = dval_q;
  assign bus.oSOF       = sof_q;
  assign bus.oEOF       = eof_q;
  assign bus.oFRAME_CNT = frame_cnt;
  assign bus.oINT_TIME  = (int_cnt != '0);
endmodule

// File: tb/tb_sensor_frame_capture.sv
// Directed bench for sensor_frame_capture: sequencer timing, ROI/decimation
// table, exposure restart and mid-frame reset.
module tb_sensor_frame_capture;
  localparam int unsigned ADC_W = 10;
  localparam int unsigned OUT_W = 8;
  localparam int unsigned ROW_W = 9;
  localparam int unsigned COL_W = 10;
  localparam int unsigned DEC_W = 5;
  localparam int unsigned INT_W = 21;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #6 clk = ~clk;

  sensor_frame_capture_if #(
    .ADC_W(ADC_W), .OUT_W(OUT_W), .ROW_W(ROW_W),
    .COL_W(COL_W), .DEC_W(DEC_W), .INT_W(INT_W)
  ) bus ();

  sensor_frame_capture #(
    .ADC_W(ADC_W), .OUT_W(OUT_W), .PWRUP_CYC(100), .RSTH_CYC(5),
    .ROW_W(ROW_W), .COL_W(COL_W), .DEC_W(DEC_W), .INT_W(INT_W)
  ) dut (
    .iCLOCK_80(clk),
    .iRST_N(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int n_dval, n_sof, n_eof, n_int;
  int fc_exp = 0;
  logic [9:0] d1 = '0, d2 = '0;

  typedef struct {
    int dec, rs, rn, cs, cn, ilen, nfr, rows, cols;
    int e_dval, e_sof, e_eof, e_int;
  } vec_t;
  vec_t tbl[6];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int outs();
    return 32'({bus.oRST_N, bus.oCFG_START, bus.oDATA, bus.oDVAL, bus.oSOF,
                bus.oEOF, bus.oFRAME_CNT, bus.oINT_TIME, bus.oREADY});
  endfunction

  // Output monitor: counts strobes and checks each written pixel against
  // the stimulus two cycles earlier and against the ROI window.
  always @(negedge clk) begin
    int r, c;
    if (bus.oDVAL) begin
      n_dval++;
      r = int'(bus.oDATA[7:4]);
      c = int'(bus.oDATA[3:0]);
      checks++;
      if (bus.oDATA != d2[9:2] ||
          r < int'(bus.iROW_START) || r >= int'(bus.iROW_START) + int'(bus.iROW_NUM) ||
          c < int'(bus.iCOL_START) || c >= int'(bus.iCOL_START) + int'(bus.iCOL_NUM)) begin
        errors++;
        $display("FAIL dval_pixel actual %0h expected %0h (row %0d col %0d)",
                 bus.oDATA, d2[9:2], r, c);
      end
    end
    if (bus.oSOF)      n_sof++;
    if (bus.oEOF)      n_eof++;
    if (bus.oINT_TIME) n_int++;
    d2 = d1;
    d1 = bus.iADATA;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.Frame_Valid = 1'b0;
    bus.Line_Valid  = 1'b0;
    repeat (n) tick();
  endtask

  task automatic clr_counts();
    n_dval = 0; n_sof = 0; n_eof = 0; n_int = 0;
  endtask

  // Lines of a frame whose FVAL is already high: each line is cols LVAL
  // cycles then 2 blank cycles; then FVAL drops for gap cycles.
  task automatic frame_body(input int rows, input int cols, input int gap);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        bus.Line_Valid = 1'b1;
        bus.iADATA     = {4'(r), 4'(c), 2'b01};
        tick();
      end
      bus.Line_Valid = 1'b0;
      bus.iADATA     = 10'h2AA;
      repeat (2) tick();
    end
    idle(gap);
  endtask

  task automatic send_frame(input int rows, input int cols, input int gap);
    bus.Frame_Valid = 1'b1;
    bus.Line_Valid  = 1'b0;
    repeat (2) tick();
    frame_body(rows, cols, gap);
  endtask

  task automatic set_roi(input int dec, input int rs, input int rn,
                         input int cs, input int cn, input int ilen);
    bus.iDEC       = DEC_W'(dec);
    bus.iROW_START = ROW_W'(rs);
    bus.iROW_NUM   = ROW_W'(rn);
    bus.iCOL_START = COL_W'(cs);
    bus.iCOL_NUM   = COL_W'(cn);
    bus.iINT_LEN   = INT_W'(ilen);
  endtask

  initial begin
    int rst_at, cfg_at, cfg_n;
    bit seen;

    //        dec  rs  rn  cs   cn ilen nfr rows cols  dval sof eof int
    tbl[0] = '{0,   1,  2,  2,   4,  7,  1,  4,   8,    8,  1,  1,  7};
    tbl[1] = '{0,   0,  4,  0,   8,  0,  1,  4,   8,   32,  1,  1,  0};
    tbl[2] = '{0,   0,  4,  0,   0,  3,  1,  4,   8,    0,  1,  1,  3};
    tbl[3] = '{0, 510, 10,  0,   8,  1,  1,  4,   8,    0,  1,  1,  1};
    tbl[4] = '{0,   2,100,  5, 500,  5,  1,  4,   8,    6,  1,  1,  5};
    tbl[5] = '{3,   0,  4,  0,   8,  2, 10,  4,   8,   96,  3,  3, 20};

    bus.iADATA = '0; bus.Line_Valid = 1'b0; bus.Frame_Valid = 1'b0;
    bus.iCFG_DONE = 1'b0;
    set_roi(0, 0, 4, 0, 8, 0);
    clr_counts();

    // Reset state and power-up sequencing
    repeat (3) tick();
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    rst_at = 0; cfg_at = 0; cfg_n = 0;
    for (int n = 1; n <= 130; n++) begin
      tick();
      if (bus.oRST_N && rst_at == 0) rst_at = n;
      if (bus.oCFG_START) begin
        cfg_n++;
        if (cfg_at == 0) cfg_at = n;
      end
    end
    check("orst_n_rise_cycle", rst_at, 100);
    check("cfg_start_cycle", cfg_at, 106);
    check("cfg_start_pulses", cfg_n, 1);
    check("ready_before_done", int'(bus.oREADY), 0);
    bus.iCFG_DONE = 1'b1;
    tick();
    check("ready_after_done", int'(bus.oREADY), 1);
    check("orst_n_in_run", int'(bus.oRST_N), 1);

    // Table-driven ROI / decimation / exposure vectors
    for (int i = 0; i < 6; i++) begin
      set_roi(tbl[i].dec, tbl[i].rs, tbl[i].rn, tbl[i].cs, tbl[i].cn, tbl[i].ilen);
      clr_counts();
      for (int f = 0; f < tbl[i].nfr; f++) send_frame(tbl[i].rows, tbl[i].cols, 10);
      idle(30);
      fc_exp = (fc_exp + tbl[i].nfr) % 256;
      check($sformatf("v%0d_dval", i), n_dval, tbl[i].e_dval);
      check($sformatf("v%0d_sof", i), n_sof, tbl[i].e_sof);
      check($sformatf("v%0d_eof", i), n_eof, tbl[i].e_eof);
      check($sformatf("v%0d_int", i), n_int, tbl[i].e_int);
      check($sformatf("v%0d_frame_cnt", i), int'(bus.oFRAME_CNT), fc_exp);
    end

    // Exposure restart: two frame ends 10 cycles apart with a 20-cycle pulse
    set_roi(0, 0, 4, 0, 8, 20);
    clr_counts();
    send_frame(1, 2, 4);
    send_frame(1, 2, 4);
    idle(40);
    fc_exp = (fc_exp + 2) % 256;
    check("int_restart_len", n_int, 30);
    check("int_restart_frame_cnt", int'(bus.oFRAME_CNT), fc_exp);

    // Reset during an active write strobe
    set_roi(0, 0, 4, 0, 8, 0);
    bus.Frame_Valid = 1'b1;
    bus.Line_Valid  = 1'b0;
    repeat (2) tick();
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      bus.Line_Valid = 1'b1;
      bus.iADATA     = {4'd0, 4'(c), 2'b01};
      tick();
      if (bus.oDVAL) seen = 1'b1;
    end
    check("dval_before_reset", int'(seen), 1);
    rst_n = 1'b0;
    bus.iCFG_DONE = 1'b0;
    tick();
    check("midframe_reset_outputs", outs(), 0);
    bus.Line_Valid = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (120) tick();
    check("cfg_held_while_fval", int'(bus.oREADY), 0);
    bus.Frame_Valid = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      if (bus.oCFG_START) seen = 1'b1;
    end
    check("cfg_start_after_fval_low", int'(seen), 1);

    // RUN reached mid-frame: that frame is not captured or counted
    clr_counts();
    bus.Frame_Valid = 1'b1;
    tick();
    bus.iCFG_DONE = 1'b1;
    tick();
    frame_body(4, 8, 10);
    check("midrun_ready", int'(bus.oREADY), 1);
    check("midrun_dval", n_dval, 0);
    check("midrun_sof", n_sof, 0);
    check("midrun_eof", n_eof, 0);
    check("midrun_frame_cnt", int'(bus.oFRAME_CNT), 0);

    clr_counts();
    send_frame(4, 8, 10);
    idle(30);
    check("post_reset_dval", n_dval, 32);
    check("post_reset_sof", n_sof, 1);
    check("post_reset_eof", n_eof, 1);
    check("post_reset_frame_cnt", int'(bus.oFRAME_CNT), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
